// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg -- one-stage valid/ready pipeline register with optional skid entry.
//
// SKID=1: two entries (main + skid). in_ready comes straight from a flop, so there
//         is no combinational path from out_ready back to in_ready.
// SKID=0: one entry. in_ready = !out_valid || out_ready (combinational).
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      drop every held entry and any same-cycle input
//   in_valid   upstream payload present
//   in_ready   stage can take in_data this cycle
//   in_data    upstream payload [DATA_W]
//   out_valid  out_data is valid
//   out_ready  downstream takes out_data this cycle
//   out_data   oldest held payload [DATA_W]
//   stall_cnt  saturating count of cycles with out_valid && !out_ready [STALL_W]
module pipe_skid_reg #(
    parameter int DATA_W  = 32,
    parameter int SKID    = 1,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [STALL_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              accept;
    logic              fire;
    logic              ld_main_in;
    logic              ld_main_skid;
    logic              ld_skid;

    assign out_valid = (state != ST_EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;

    generate
        if (SKID != 0) begin : g_skid
            // Ready is precomputed from the next state so it is valid from the
            // flop output; it reads 0 while rst is applied.
            logic rdy_q;
            always_ff @(posedge clk) begin
                if (rst) rdy_q <= 1'b0;
                else     rdy_q <= (state_nxt != ST_FULL);
            end
            assign in_ready = rdy_q;
        end else begin : g_noskid
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_EMPTY;
        else     state <= state_nxt;
    end

    // Next-state logic; flush wins over all handshakes
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) state_nxt = ST_BUSY;
                ST_BUSY: begin
                    if (accept && !fire) begin
                        // Unreachable for SKID=0: accepting while full needs a fire
                        if (SKID != 0) state_nxt = ST_FULL;
                    end else if (fire && !accept) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL:  if (fire) state_nxt = ST_BUSY;
                default:  state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Load controls; nothing loads in a flush cycle so a discarded payload
    // never shows up on out_data.
    always_comb begin
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (!flush) begin
            case (state)
                ST_EMPTY: ld_main_in = accept;
                ST_BUSY: begin
                    if (accept && fire)  ld_main_in = 1'b1;
                    else if (accept) begin
                        if (SKID != 0)   ld_skid    = 1'b1;
                        else             ld_main_in = 1'b1;
                    end
                end
                ST_FULL:  ld_main_skid = fire;
                default:  ;
            endcase
        end
    end

    // Payload registers
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_main_in)        main_q <= in_data;
            else if (ld_main_skid) main_q <= skid_q;
            if (ld_skid)           skid_q <= in_data;
        end
    end

    // Back-pressure counter; survives flush, only rst clears it
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: SKID=1 default instance, SKID=1 with a
// 2-bit stall counter, and a SKID=0 instance, all sharing one input stream.
module tb_pipe_skid_reg;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [DW-1:0] in_data;

    logic          a_in_ready, a_out_valid;
    logic [DW-1:0] a_out_data;
    logic [15:0]   a_stall;
    logic          b_in_ready, b_out_valid;
    logic [DW-1:0] b_out_data;
    logic [1:0]    b_stall;
    logic          c_in_ready, c_out_valid;
    logic [DW-1:0] c_out_data;
    logic [3:0]    c_stall;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_W(DW), .SKID(1), .STALL_W(16)) u_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .stall_cnt(a_stall)
    );

    pipe_skid_reg #(.DATA_W(DW), .SKID(1), .STALL_W(2)) u_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .stall_cnt(b_stall)
    );

    pipe_skid_reg #(.DATA_W(DW), .SKID(0), .STALL_W(4)) u_c (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
        .stall_cnt(c_stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a_seq [3];
        int         b_exp [6];
        a_seq = '{8'hA1, 8'hA2, 8'hA3};
        b_exp = '{1, 2, 3, 3, 3, 3};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        step; step;
        check("rst_ovalid", 32'(a_out_valid), 32'd0);
        check("rst_odata",  32'(a_out_data),  32'd0);
        check("rst_irdy",   32'(a_in_ready),  32'd0);
        check("rst_stall",  32'(a_stall),     32'd0);
        check("rst_s0_ovalid", 32'(c_out_valid), 32'd0);
        rst = 1'b0;
        step;
        check("post_rst_irdy",   32'(a_in_ready),  32'd1);
        check("post_rst_ovalid", 32'(a_out_valid), 32'd0);

        // Streaming with out_ready held high
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = a_seq[i];
            step;
            check("stream_ovalid", 32'(a_out_valid), 32'd1);
            check("stream_odata",  32'(a_out_data),  32'(a_seq[i]));
            check("stream_irdy",   32'(a_in_ready),  32'd1);
        end
        in_valid = 1'b0;
        step;
        check("stream_drain", 32'(a_out_valid), 32'd0);
        check("stream_stall", 32'(a_stall),     32'd0);

        // Stall counter saturation on the 2-bit instance
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
        step;
        check("sat_ovalid", 32'(b_out_valid), 32'd1);
        check("sat_stall0", 32'(b_stall),     32'd0);
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step;
            check("sat_stall", 32'(b_stall), 32'(b_exp[i]));
        end
        check("wide_stall", 32'(a_stall), 32'd6);
        out_ready = 1'b1;
        step;
        check("sat_drain", 32'(a_out_valid), 32'd0);

        // Fill main then skid under back-pressure
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11;
        step;
        check("fill1_odata", 32'(a_out_data), 32'h11);
        check("fill1_irdy",  32'(a_in_ready), 32'd1);
        check("fill1_stall", 32'(a_stall),    32'd6);
        in_data = 8'h22;
        step;
        check("full_irdy",   32'(a_in_ready),  32'd0);
        check("full_odata",  32'(a_out_data),  32'h11);
        check("full_ovalid", 32'(a_out_valid), 32'd1);
        check("full_stall",  32'(a_stall),     32'd7);
        in_data = 8'h99;
        step;
        check("hold_irdy",  32'(a_in_ready), 32'd0);
        check("hold_odata", 32'(a_out_data), 32'h11);
        check("hold_stall", 32'(a_stall),    32'd8);
        in_valid = 1'b0;

        // Drain: ready must not react combinationally to out_ready
        out_ready = 1'b1;
        #1;
        check("irdy_registered", 32'(a_in_ready), 32'd0);
        step;
        check("drain1_odata",  32'(a_out_data),  32'h22);
        check("drain1_ovalid", 32'(a_out_valid), 32'd1);
        check("drain1_irdy",   32'(a_in_ready),  32'd1);
        check("drain1_stall",  32'(a_stall),     32'd8);
        step;
        check("drain2_ovalid", 32'(a_out_valid), 32'd0);
        check("drain2_irdy",   32'(a_in_ready),  32'd1);
        check("drain2_odata",  32'(a_out_data),  32'h22);

        // Flush from FULL with a same-cycle input
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h44;
        step;
        in_data = 8'h55;
        step;
        check("pre_flush_irdy",  32'(a_in_ready), 32'd0);
        check("pre_flush_stall", 32'(a_stall),    32'd9);
        flush = 1'b1; in_data = 8'h33;
        step;
        check("flush_ovalid", 32'(a_out_valid), 32'd0);
        check("flush_odata",  32'(a_out_data),  32'h44);
        check("flush_irdy",   32'(a_in_ready),  32'd1);
        check("flush_stall",  32'(a_stall),     32'd10);
        flush = 1'b0; in_valid = 1'b0;
        step;
        check("post_flush_ovalid", 32'(a_out_valid), 32'd0);
        check("post_flush_odata",  32'(a_out_data),  32'h44);

        // Reset from FULL while handshakes are active
        in_valid = 1'b1; in_data = 8'h66;
        step;
        in_data = 8'h77;
        step;
        check("pre_rst_irdy", 32'(a_in_ready), 32'd0);
        rst = 1'b1; out_ready = 1'b1; in_data = 8'h88;
        step;
        check("mid_rst_ovalid", 32'(a_out_valid), 32'd0);
        check("mid_rst_odata",  32'(a_out_data),  32'd0);
        check("mid_rst_irdy",   32'(a_in_ready),  32'd0);
        check("mid_rst_stall",  32'(a_stall),     32'd0);
        rst = 1'b0; in_valid = 1'b0;
        step;
        check("rerdy_irdy",   32'(a_in_ready),  32'd1);
        check("rerdy_ovalid", 32'(a_out_valid), 32'd0);
        in_valid = 1'b1; in_data = 8'h99;
        step;
        check("reacc_ovalid", 32'(a_out_valid), 32'd1);
        check("reacc_odata",  32'(a_out_data),  32'h99);
        // rst pulse between edges must not disturb state
        in_valid = 1'b0; rst = 1'b1;
        #2;
        check("async_ovalid", 32'(a_out_valid), 32'd1);
        check("async_odata",  32'(a_out_data),  32'h99);
        check("async_irdy",   32'(a_in_ready),  32'd1);
        rst = 1'b0;
        step;
        check("reacc_drain",   32'(a_out_valid), 32'd0);
        check("s0_reacc_drain", 32'(c_out_valid), 32'd0);

        // SKID=0: in_ready follows out_ready while out_valid
        in_valid = 1'b1; in_data = 8'hA1; out_ready = 1'b1;
        #1;
        check("s0_irdy_empty", 32'(c_in_ready), 32'd1);
        step;
        check("s0_ovalid", 32'(c_out_valid), 32'd1);
        check("s0_odata1", 32'(c_out_data),  32'hA1);
        out_ready = 1'b0; in_data = 8'hA2;
        #1;
        check("s0_irdy_lo", 32'(c_in_ready), 32'd0);
        step;
        check("s0_hold_odata",  32'(c_out_data),  32'hA1);
        check("s0_hold_ovalid", 32'(c_out_valid), 32'd1);
        out_ready = 1'b1;
        #1;
        check("s0_irdy_hi", 32'(c_in_ready), 32'd1);
        step;
        check("s0_odata2", 32'(c_out_data), 32'hA2);
        in_valid = 1'b0;
        step;
        check("s0_drain", 32'(c_out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
